wrr_grant_scheduler: RTL and testbench

WRR_GRANT_SCHEDULER -- requirements
Module: wrr_grant_scheduler

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 23 ++
 rtl/wrr_grant_scheduler.sv | 112 +++++++++++
 tb/tb_wrr_grant_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared arbitration types: FSM state encoding and a width-generic one-hot to index helper.
package arb_pkg;

    // One-hot encoding leaves the other two codes illegal; the FSM maps them back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        GRANT = 2'b10
    } state_t;

    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: lowest requester inside the mask, else lowest requester overall.
module rr_pick
    import arb_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int IW       = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CHANNELS-1:0] mask,
    output logic [CHANNELS-1:0] onehot,
    output logic [IW-1:0]       idx
);

    logic [CHANNELS-1:0] masked;
    logic [CHANNELS-1:0] pool;

    assign masked = req & mask;
    assign pool   = (|masked) ? masked : req;
    // Isolate the lowest set bit (two's-complement trick).
    assign onehot = pool & (~pool + CHANNELS'(1));
    assign idx    = IW'(onehot_to_idx(32'(onehot)));

endmodule

// File: rtl/wrr_grant_scheduler.sv
// Weighted round-robin grant scheduler with a valid/ready grant handshake and per-channel burst weights.
module wrr_grant_scheduler
    import arb_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int WEIGHT_W = 4,
    parameter int MODE     = 1,
    parameter int IW       = $clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WEIGHT_W-1:0] weight,
    output logic [CHANNELS-1:0]          gnt,
    output logic [IW-1:0]                gnt_id,
    output logic                         gnt_valid,
    input  logic                         gnt_ready,
    output logic                         gnt_last,
    output logic [CHANNELS-1:0]          priorities
);

    state_t              state, state_n;
    logic [CHANNELS-1:0] gnt_n, pri_n, above, pick_mask, pick_oh;
    logic [IW-1:0]       id_n, pick_idx;
    logic [WEIGHT_W-1:0] cnt, cnt_n, win_w, load_cnt;
    logic                load;

    // Channels strictly above the current winner; wraps to all-ones after the top channel.
    always_comb begin
        above = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i > int'(gnt_id)) above[i] = 1'b1;
        end
        if (gnt_id == IW'(CHANNELS - 1)) above = '1;
    end

    // In GRANT the mask is the post-acceptance ranking, so one picker serves both load paths.
    assign pick_mask = (state == GRANT) ? above : priorities;

    rr_pick #(.CHANNELS(CHANNELS), .IW(IW)) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    assign win_w    = weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
    assign load_cnt = (MODE == 1 && win_w != '0) ? win_w - WEIGHT_W'(1) : '0;

    assign gnt_valid = (state == GRANT);
    assign gnt_last  = gnt_valid & ((cnt == '0) | ~req[gnt_id]);

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        id_n    = gnt_id;
        cnt_n   = cnt;
        pri_n   = priorities;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) load = 1'b1;
            end
            GRANT: begin
                if (gnt_ready) begin
                    if (!gnt_last) begin
                        cnt_n = cnt - WEIGHT_W'(1);
                    end else begin
                        pri_n = above;
                        if (|req) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                            gnt_n   = '0;
                            id_n    = '0;
                            cnt_n   = '0;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                id_n    = '0;
                cnt_n   = '0;
            end
        endcase
        if (load) begin
            state_n = GRANT;
            gnt_n   = pick_oh;
            id_n    = pick_idx;
            cnt_n   = load_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            gnt_id     <= '0;
            cnt        <= '0;
            priorities <= '1;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            gnt_id     <= id_n;
            cnt        <= cnt_n;
            priorities <= pri_n;
        end
    end

endmodule

// File: tb/tb_wrr_grant_scheduler.sv
// Scoreboard bench: one plain round-robin instance and one weighted instance, directed vectors.
module tb_wrr_grant_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req_a, req_b;
    logic [31:0] w_a, w_b;
    logic        rdy_a, rdy_b;
    logic [7:0]  gnt_a, gnt_b, pri_a, pri_b;
    logic [2:0]  id_a, id_b;
    logic        valid_a, valid_b, last_a, last_b;

    typedef struct {
        logic [2:0] id;
        logic       last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wrr_grant_scheduler #(.CHANNELS(8), .WEIGHT_W(4), .MODE(0)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .weight(w_a),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(valid_a), .gnt_ready(rdy_a),
        .gnt_last(last_a), .priorities(pri_a)
    );

    wrr_grant_scheduler #(.CHANNELS(8), .WEIGHT_W(4), .MODE(1)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .weight(w_b),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(valid_b), .gnt_ready(rdy_b),
        .gnt_last(last_b), .priorities(pri_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_a = '0; rdy_a = 1'b0; w_a = {8{4'h5}};
        req_b = '0; rdy_b = 1'b0; w_b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (valid_a && rdy_a) begin
                        if (qa.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL a_unexpected_beat: got id %0d, expected no beat", id_a);
                        end else begin
                            e = qa.pop_front();
                            chk("a_gnt_id", 32'(id_a), 32'(e.id));
                            chk("a_gnt_last", 32'(last_a), 32'(e.last));
                            chk("a_gnt_onehot", 32'(gnt_a), 32'(8'd1 << e.id));
                        end
                    end
                    if (valid_b && rdy_b) begin
                        if (qb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL b_unexpected_beat: got id %0d, expected no beat", id_b);
                        end else begin
                            e = qb.pop_front();
                            chk("b_gnt_id", 32'(id_b), 32'(e.id));
                            chk("b_gnt_last", 32'(last_b), 32'(e.last));
                            chk("b_gnt_onehot", 32'(gnt_b), 32'(8'd1 << e.id));
                        end
                    end
                end
            end
            begin : stimulus
                // Idle after reset
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("idle_valid_a", 32'(valid_a), 32'd0);
                    chk("idle_pri_a", 32'(pri_a), 32'hFF);
                    chk("idle_valid_b", 32'(valid_b), 32'd0);
                    chk("idle_pri_b", 32'(pri_b), 32'hFF);
                    chk("idle_gnt_b", 32'(gnt_b), 32'h00);
                end

                // Plain round-robin, all requesting
                @(posedge clk); #1;
                req_a = 8'hFF; rdy_a = 1'b1;
                for (int k = 0; k < 9; k++) qa.push_back('{id: 3'(k % 8), last: 1'b1});
                for (int i = 0; i < 9; i++) begin
                    @(posedge clk); #1;
                    if (i == 8) req_a = 8'h00;
                    @(negedge clk);
                    chk("rr_no_bubble", 32'(valid_a), 32'd1);
                end
                @(posedge clk); #1;
                rdy_a = 1'b0;
                @(negedge clk);
                chk("rr_idle_valid", 32'(valid_a), 32'd0);
                chk("rr_idle_gnt", 32'(gnt_a), 32'h00);
                chk("rr_idle_pri", 32'(pri_a), 32'hFE);

                // Weighted: ch0 weight 3, ch1 weight 1
                @(posedge clk); #1;
                w_b[0 +: 4] = 4'd3; w_b[4 +: 4] = 4'd1;
                req_b = 8'h03; rdy_b = 1'b1;
                for (int r = 0; r < 2; r++) begin
                    qb.push_back('{id: 3'd0, last: 1'b0});
                    qb.push_back('{id: 3'd0, last: 1'b0});
                    qb.push_back('{id: 3'd0, last: 1'b1});
                    qb.push_back('{id: 3'd1, last: 1'b1});
                end
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk); #1;
                    if (i == 7) req_b = 8'h00;
                    @(negedge clk);
                end
                @(posedge clk); #1;
                rdy_b = 1'b0;
                @(negedge clk);
                chk("wrr_idle_valid", 32'(valid_b), 32'd0);
                chk("wrr_idle_pri", 32'(pri_b), 32'hFC);

                // Stalled grant to ch2 while its request drops
                @(posedge clk); #1;
                w_b[8 +: 4] = 4'd3; w_b[16 +: 4] = 4'd1;
                req_b = 8'h14;
                @(posedge clk); #1;
                @(negedge clk);
                chk("stall_gnt_first", 32'(gnt_b), 32'h04);
                chk("stall_last_first", 32'(last_b), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    @(posedge clk); #1;
                    if (i == 0) req_b = 8'h10;
                    @(negedge clk);
                    chk("stall_gnt_hold", 32'(gnt_b), 32'h04);
                    chk("stall_valid_hold", 32'(valid_b), 32'd1);
                end
                chk("stall_last_after_drop", 32'(last_b), 32'd1);
                @(posedge clk); #1;
                qb.push_back('{id: 3'd2, last: 1'b1});
                qb.push_back('{id: 3'd4, last: 1'b1});
                rdy_b = 1'b1;
                @(posedge clk); #1;
                req_b = 8'h00;
                @(posedge clk); #1;
                rdy_b = 1'b0;
                @(negedge clk);
                chk("stall_end_valid", 32'(valid_b), 32'd0);
                chk("stall_end_gnt", 32'(gnt_b), 32'h00);
                chk("stall_end_pri", 32'(pri_b), 32'hE0);

                // Sole requester ch5 (weight 0 acts as 1) wraps to itself, then IDLE
                @(posedge clk); #1;
                w_b[20 +: 4] = 4'd0;
                req_b = 8'h20; rdy_b = 1'b1;
                qb.push_back('{id: 3'd5, last: 1'b1});
                qb.push_back('{id: 3'd5, last: 1'b1});
                @(posedge clk); #1;
                @(posedge clk); #1;
                req_b = 8'h00;
                @(posedge clk); #1;
                rdy_b = 1'b0;
                @(negedge clk);
                chk("wrap_idle_valid", 32'(valid_b), 32'd0);
                chk("wrap_idle_gnt", 32'(gnt_b), 32'h00);
                chk("wrap_idle_pri", 32'(pri_b), 32'hC0);

                // Reset in the middle of a ch1 burst (counter at 2)
                @(posedge clk); #1;
                w_b[4 +: 4] = 4'd4;
                req_b = 8'h02; rdy_b = 1'b1;
                qb.push_back('{id: 3'd1, last: 1'b0});
                qb.push_back('{id: 3'd1, last: 1'b0});
                qb.push_back('{id: 3'd0, last: 1'b0});
                @(posedge clk); #1;
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0; req_b = 8'h81;
                @(negedge clk);
                chk("rst_mid_valid", 32'(valid_b), 32'd0);
                chk("rst_mid_pri", 32'(pri_b), 32'hFF);
                chk("rst_mid_gnt", 32'(gnt_b), 32'h00);
                chk("rst_mid_id", 32'(id_b), 32'd0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("post_rst_winner", 32'(gnt_b), 32'h01);
                @(posedge clk); #1;
                rdy_b = 1'b0; req_b = 8'h00;
                @(negedge clk);

                chk("qa_drained", 32'(qa.size()), 32'd0);
                chk("qb_drained", 32'(qb.size()), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
